// File: rtl/dma_controller_pkg.sv
// Shared definitions for the DMA bus-master engine: FSM state encodings and transfer length.
// DMA_LAST_IDX is also consumed by the CPU hazard/stall logic to detect release.
package dma_controller_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int XFER_LEN_DEFAULT = 12;
  localparam int DMA_LAST_IDX     = XFER_LEN_DEFAULT - 1;

endpackage

// File: rtl/dma_controller.sv
// DMA engine: takes a CPU command, requests the bus (BR/BG), copies XFER_LEN device words to memory.
// Optional abort support is compiled in with `define DMA_ABORT_EN.
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int XFER_LEN  = XFER_LEN_DEFAULT,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  output logic                 cmd_ready,
  output logic                 BR,
  input  logic                 BG,
  input  logic [WORD_SIZE-1:0] dev_data,
  input  logic                 dev_valid,
  output logic                 dev_ready,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data,
  output logic                 mem_write,
  input  logic                 mem_ack,
  output logic [CNT_W-1:0]     dma_counter,
  output logic                 dma_end,
`ifdef DMA_ABORT_EN
  input  logic                 abort,
  output logic                 dma_aborted,
`endif
  output logic [2:0]           dbg_state
);

  // Handshakes: a transfer happens on the rising clk edge where valid && ready are both 1;
  // the producer holds valid and its payload stable until that edge.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(XFER_LEN - 1);

  logic [2:0]           state;
  logic [WORD_SIZE-1:0] base_addr;
  logic                 dev_ready_q;
  logic [CNT_W-1:0]     cnt_next;
  logic                 take;
  logic                 abort_now;
  logic                 abort_seen;

`ifdef DMA_ABORT_EN
  logic abort_pend;
  assign abort_now  = abort;
  assign abort_seen = abort_pend | abort;
`else
  assign abort_now  = 1'b0;
  assign abort_seen = 1'b0;
`endif

  // A withdrawn grant (or an abort) must block the device handshake in the same cycle.
  assign dev_ready = dev_ready_q & BG & ~abort_now;
  assign take      = dev_valid & dev_ready;
  assign cnt_next  = dma_counter + CNT_W'(1);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      base_addr   <= '0;
      cmd_ready   <= 1'b1;
      BR          <= 1'b0;
      dev_ready_q <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_write   <= 1'b0;
      dma_counter <= '0;
      dma_end     <= 1'b0;
    end else begin
      dma_end <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            base_addr   <= cmd_addr;
            mem_addr    <= cmd_addr;
            dma_counter <= '0;
            BR          <= 1'b1;
            cmd_ready   <= 1'b0;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (abort_now) begin
            BR      <= 1'b0;
            dma_end <= 1'b1;
            state   <= ST_DONE;
          end else if (BG) begin
            dev_ready_q <= 1'b1;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (abort_now) begin
            dev_ready_q <= 1'b0;
            BR          <= 1'b0;
            dma_end     <= 1'b1;
            state       <= ST_DONE;
          end else if (take) begin
            mem_data    <= dev_data;
            mem_write   <= 1'b1;
            dev_ready_q <= 1'b0;
            state       <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The in-flight write always completes, whatever BG or abort do meanwhile.
          if (mem_ack) begin
            mem_write <= 1'b0;
            if (dma_counter == LAST_IDX || abort_seen) begin
              BR      <= 1'b0;
              dma_end <= 1'b1;
              state   <= ST_DONE;
            end else begin
              dma_counter <= cnt_next;
              mem_addr    <= base_addr + WORD_SIZE'(cnt_next);
              dev_ready_q <= 1'b1;
              state       <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          BR          <= 1'b0;
          dev_ready_q <= 1'b0;
          mem_write   <= 1'b0;
          cmd_ready   <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DMA_ABORT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      abort_pend  <= 1'b0;
      dma_aborted <= 1'b0;
    end else if (state == ST_IDLE && cmd_valid) begin
      abort_pend  <= 1'b0;
      dma_aborted <= 1'b0;
    end else if (abort && (state == ST_REQ || state == ST_FETCH || state == ST_WRITE)) begin
      abort_pend  <= 1'b1;
      dma_aborted <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: random device data and handshake timing against a
// transfer-level reference (expected {addr,data} list per command). Abort test needs DMA_ABORT_EN.
module tb_dma_controller;

  localparam int W  = 16;
  localparam int N  = 12;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [W-1:0]  cmd_addr = '0;
  logic          cmd_ready;
  logic          BR;
  logic          BG = 1'b0;
  logic [W-1:0]  dev_data = '0;
  logic          dev_valid = 1'b0;
  logic          dev_ready;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_data;
  logic          mem_write;
  logic          mem_ack = 1'b0;
  logic [CW-1:0] dma_counter;
  logic          dma_end;
  logic [2:0]    dbg_state;
`ifdef DMA_ABORT_EN
  logic          abort = 1'b0;
  logic          dma_aborted;
`endif

  dma_controller #(.WORD_SIZE(W), .XFER_LEN(N), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
    .BR(BR), .BG(BG),
    .dev_data(dev_data), .dev_valid(dev_valid), .dev_ready(dev_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write), .mem_ack(mem_ack),
    .dma_counter(dma_counter), .dma_end(dma_end),
`ifdef DMA_ABORT_EN
    .abort(abort), .dma_aborted(dma_aborted),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [W-1:0] dev_q[$];
  int mem_lat     = 0;
  int writes_done = 0;
  int words_taken = 0;
  int done_cnt    = 0;
  int end_idx     = 0;
  int wcnt        = 0;
  bit end_next    = 1'b0;
  bit abort_mode  = 1'b0;
  bit prev_mw     = 1'b0;
  bit bg_prev     = 1'b0;
  logic [W-1:0] cap_addr, cap_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_br"},        32'(BR), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_dev_ready"}, 32'(dev_ready), 32'd0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_mem_data"},  32'(mem_data), 32'd0);
    check({tag, "_counter"},   32'(dma_counter), 32'd0);
    check({tag, "_dma_end"},   32'(dma_end), 32'd0);
`ifdef DMA_ABORT_EN
    check({tag, "_aborted"},   32'(dma_aborted), 32'd0);
`endif
  endtask

  // ---------------- device / memory models + scoreboard ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      mem_ack   = 1'b0;
      dev_valid = 1'b0;
      wcnt      = 0;
      prev_mw   = 1'b0;
      bg_prev   = 1'b0;
    end else begin
      if (end_next) begin
        check("end_pulse",     32'(dma_end), 32'd1);
        check("end_br_low",    32'(BR), 32'd0);
        check("end_cmd_ready", 32'(cmd_ready), 32'd0);
        check("end_counter",   32'(dma_counter), 32'(end_idx));
        end_next = 1'b0;
        done_cnt++;
      end else begin
        check("end_idle", 32'(dma_end), 32'd0);
      end
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (mem_write) begin
        if (wcnt >= mem_lat) mem_ack = 1'b1;
        else wcnt++;
      end
      dev_valid = (dev_q.size() > 0) && ($urandom_range(0, 3) != 0);
      dev_data  = (dev_q.size() > 0) ? dev_q[0] : W'($urandom);
      #1;
      if (mem_write && !prev_mw) begin
        cap_addr = mem_addr;
        cap_data = mem_data;
      end
      if (!BG) check("no_ready_without_grant", 32'(dev_ready), 32'd0);
      if (!bg_prev && !prev_mw) check("no_write_without_grant", 32'(mem_write), 32'd0);
      if (dev_valid && dev_ready) begin
        check("take_with_grant", 32'(BG), 32'd1);
        void'(dev_q.pop_front());
        words_taken++;
      end
      if (mem_write && mem_ack) begin
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("write_addr",    32'(mem_addr), 32'(e[31:16]));
          check("write_data",    32'(mem_data), 32'(e[15:0]));
          check("write_counter", 32'(dma_counter), 32'(writes_done));
          check("addr_stable",   32'(mem_addr), 32'(cap_addr));
          check("data_stable",   32'(mem_data), 32'(cap_data));
          writes_done++;
          if (exp_q.size() == 0 || abort_mode) begin
            end_next = 1'b1;
            end_idx  = writes_done - 1;
            exp_q.delete();
            dev_q.delete();
          end
        end
      end
      prev_mw = mem_write;
      bg_prev = BG;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic [W-1:0] addr, input int bg_delay);
    @(negedge clk);
    exp_q.delete();
    dev_q.delete();
    writes_done = 0;
    words_taken = 0;
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] w;
      logic [W-1:0] a;
      w = W'($urandom);
      a = addr + W'(i);
      dev_q.push_back(w);
      exp_q.push_back({a, w});
    end
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    #1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    check("br_before_accept", 32'(BR), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("br_latency", 32'(BR), 32'd1);
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    repeat (bg_delay) @(negedge clk);
    BG = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int start;
    bit seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = (done_cnt > start);
    end
    check("done_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic wait_writes(input int count, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = (writes_done == count) && mem_write;
    end
    check("reach_write", 32'(seen), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // 1: nominal transfer, then a command offered during the DONE cycle
    mem_lat = 0;
    start_cmd(16'h0100, 3);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        #2;
        seen = dma_end;
      end
      check("nominal_end_seen", 32'(seen), 32'd1);
      cmd_valid = 1'b1;
      cmd_addr  = 16'h4444;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      check("cmd_in_done_rejected", 32'(BR), 32'd0);
      check("idle_after_done", 32'(cmd_ready), 32'd1);
      check("nominal_count", 32'(writes_done), 32'(N));
      check("counter_hold", 32'(dma_counter), 32'(N - 1));
    end
    BG = 1'b0;

    // 2: grant withdrawn for 5 cycles after word 4
    start_cmd(16'h2000, 1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        #2;
        seen = (words_taken >= 5);
      end
      check("pause_point", 32'(seen), 32'd1);
    end
    @(negedge clk);
    BG = 1'b0;
    repeat (5) @(negedge clk);
    BG = 1'b1;
    wait_done(300);
    check("pause_count", 32'(writes_done), 32'(N));
    BG = 1'b0;

    // 3: memory latency
    mem_lat = 3;
    start_cmd(16'h3456, 2);
    wait_done(500);
    check("latency_count", 32'(writes_done), 32'(N));
    BG = 1'b0;

    // 4: address wrap, stray command mid-transfer
    mem_lat = 0;
    start_cmd(16'hFFFA, 1);
    wait_writes(3, 200);
    cmd_valid = 1'b1;
    cmd_addr  = 16'h1234;
    @(negedge clk);
    #1;
    check("stray_cmd_not_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(300);
    check("wrap_count", 32'(writes_done), 32'(N));
    BG = 1'b0;

    // 5: asynchronous reset during the write of word 7
    mem_lat = 3;
    start_cmd(16'h0500, 0);
    wait_writes(7, 500);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    dev_q.delete();
    end_next = 1'b0;
    BG = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    mem_lat = 0;
    start_cmd(16'h0600, 2);
    wait_done(300);
    check("restart_count", 32'(writes_done), 32'(N));
    BG = 1'b0;

`ifdef DMA_ABORT_EN
    // 6: abort during the write of word 2
    mem_lat = 3;
    start_cmd(16'h0700, 1);
    wait_writes(2, 300);
    abort_mode = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(100);
    check("abort_flag", 32'(dma_aborted), 32'd1);
    check("abort_br", 32'(BR), 32'd0);
    check("abort_counter", 32'(dma_counter), 32'd2);
    check("abort_words", 32'(writes_done), 32'd3);
    abort_mode = 1'b0;
    BG = 1'b0;
    mem_lat = 0;
    start_cmd(16'h0800, 1);
    check("abort_flag_cleared", 32'(dma_aborted), 32'd0);
    wait_done(300);
    check("after_abort_count", 32'(writes_done), 32'(N));
    BG = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
